ex_div_2023211063: RTL and testbench
====================================

Name: ex_div_2023211063

Overview:
- Iterative RV32M divider inside the execute stage.
- Executes DIV/DIVU/REM/REMU using a radix-2 restoring algorithm, one quotient bit per cycle.
- Holds busy_o high while computing; the pipeline uses busy_o as stall_flag so the ex/wb pipeline register freezes.
- On completion, presents a one-cycle write-back triple (reg_waddr_o, result_o, reg_we_o) to the ex/wb register.

Parameters:
- DATA_W, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- start_i  input  1  pulse: launch a division with the current operands
- op_i  input  3  funct3: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU
- dividend_i  input  32  rs1 value
- divisor_i  input  32  rs2 value
- reg_waddr_i  input  5  destination register
- flush_i  input  1  jump/hold flush; aborts the current operation
- result_o  output  32  quotient or remainder
- ready_o  output  1  result valid, one-cycle pulse
- reg_we_o  output  1  write enable to ex/wb, equal to ready_o
- reg_waddr_o  output  5  destination, valid with ready_o
- busy_o  output  1  operation in flight; drives the pipeline stall

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; result_o=0, ready_o=0, reg_we_o=0, reg_waddr_o=0, busy_o=0; counter and internal registers cleared.
  - Reset mid-operation discards all state and produces no write.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready_o and reg_we_o drop to 0 at the next edge after any pulse.
  - start_i=1 and flush_i=0 at edge E0: latch op, reg_waddr_i, and operand magnitudes.
    - Magnitudes are taken as |x| for signed ops (op_i[0]==0), raw bits for unsigned.
  - Also latch the sign flags:
    - quotient negate = sign(dividend) XOR sign(divisor), signed ops only;
    - remainder negate = sign(dividend), signed ops only.
  - divisor_i==0: go directly to DONE with forced result:
    - quotient = 32'hFFFF_FFFF;
    - remainder = dividend_i, unmodified.
  - Otherwise go to CALC with counter=DATA_W and remainder accumulator=0; busy_o=1 from E0.
- CALC, each edge:
  - rem_acc = {rem_acc, dividend_msb} shifted left;
  - if rem_acc >= divisor: subtract and shift quotient bit 1, else shift 0;
  - decrement the counter.
  - After 32 iterations (edges E1..E32), go to DONE.
- DONE, one edge (E33 normally, E1 for divide-by-zero):
  - Register result_o: sign-corrected quotient for op_i[1]==0, sign-corrected remainder for op_i[1]==1. Negation is two's complement.
  - Register reg_waddr_o. Set ready_o=1, reg_we_o=1, busy_o=0; return to IDLE.
- Result timing: ready_o visible for exactly one cycle (E33..E34); result_o holds its value until the next completion.
- Overflow, DIV 0x8000_0000 / 0xFFFF_FFFF:
  - quotient = 0x8000_0000, remainder = 0.
  - This falls out of the magnitude algorithm; no special case is needed, but it must hold.
- start_i while busy_o=1 or in DONE: ignored; operands are not re-latched.
- flush_i=1 at any edge:
  - state returns to IDLE, busy_o=0, ready_o=0, reg_we_o=0, and the pending result is discarded;
  - flush has priority over start_i in the same cycle.
- reg_waddr_i==0: the operation still runs; reg_we_o still pulses and the register file ignores x0.
- busy_o is registered, not combinational from start_i. The decode stage holds start_i high only for the single issuing cycle.

Test Plan:
- DIVU 100/7, reg_waddr 5 -> busy_o high E0..E32; at E33 result_o=14, ready_o=reg_we_o=1 for one cycle, reg_waddr_o=5. REMU same operands -> result_o=2.
- DIV 0xFFFF_FFF9 (-7) / 2 -> 0xFFFF_FFFD (-3); REM same operands -> 0xFFFF_FFFF (-1); REM 7/-2 -> 1.
- Divide by zero: DIV 1234/0 -> 0xFFFF_FFFF after one cycle (ready at E1, busy never set beyond E0); REMU 1234/0 -> 1234.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM with same operands -> 0.
- flush_i pulsed at E10 of a DIVU -> busy_o=0 next cycle, no ready_o/reg_we_o pulse ever; a fresh DIVU 9/3 afterwards -> 3.
- start_i re-asserted at E5 with new operands during a busy DIVU 100/7 -> ignored, result 14. rst=0 at E20 -> all outputs 0, no write pulse.

Source files
------------

// File: rtl/ex_div_2023211063.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the execute stage.
// Stalls the pipeline through busy_o and hands a one-cycle write-back triple to ex/wb.
module ex_div_2023211063 #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [4:0]        reg_waddr_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic              reg_we_o,
  output logic [4:0]        reg_waddr_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;     // dividend magnitude, becomes the quotient
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic                rem_sel_q, rem_sel_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [4:0]          waddr_q, waddr_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                ready_q, ready_d;
  logic [4:0]          waddr_out_q, waddr_out_d;
  logic                busy_q, busy_d;

  logic                is_signed_s;
  logic [DATA_W:0]     rem_shift_s;
  logic                sub_ok_s;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic en);
    if (en) begin
      cond_neg = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      cond_neg = v;
    end
  endfunction

  assign is_signed_s = ~op_i[0];
  assign rem_shift_s = {rem_q, dvd_q[DATA_W-1]};
  assign sub_ok_s    = (rem_shift_s >= {1'b0, dvs_q});

  // Next-state, datapath and output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    rem_sel_d   = rem_sel_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    waddr_d     = waddr_q;
    result_d    = result_q;
    ready_d     = 1'b0;
    waddr_out_d = waddr_out_q;
    busy_d      = busy_q;

    if (flush_i) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // op_i[2] is set for every divide-group funct3
          if (start_i && op_i[2]) begin
            rem_sel_d = op_i[1];
            waddr_d   = reg_waddr_i;
            busy_d    = 1'b1;
            if (divisor_i == {DATA_W{1'b0}}) begin
              dvd_d     = {DATA_W{1'b1}};
              dvs_d     = {DATA_W{1'b0}};
              rem_d     = dividend_i;
              neg_quo_d = 1'b0;
              neg_rem_d = 1'b0;
              cnt_d     = {CNT_W{1'b0}};
              state_d   = DONE;
            end else begin
              dvd_d     = cond_neg(dividend_i, is_signed_s & dividend_i[DATA_W-1]);
              dvs_d     = cond_neg(divisor_i, is_signed_s & divisor_i[DATA_W-1]);
              rem_d     = {DATA_W{1'b0}};
              neg_quo_d = is_signed_s & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
              neg_rem_d = is_signed_s & dividend_i[DATA_W-1];
              cnt_d     = CNT_W'(DATA_W);
              state_d   = CALC;
            end
          end else begin
            busy_d = 1'b0;
          end
        end
        CALC: begin
          if (sub_ok_s) begin
            rem_d = rem_shift_s[DATA_W-1:0] - dvs_q;
            dvd_d = {dvd_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = rem_shift_s[DATA_W-1:0];
            dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
        DONE: begin
          if (rem_sel_q) begin
            result_d = cond_neg(rem_q, neg_rem_q);
          end else begin
            result_d = cond_neg(dvd_q, neg_quo_q);
          end
          waddr_out_d = waddr_q;
          ready_d     = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      dvd_q       <= {DATA_W{1'b0}};
      dvs_q       <= {DATA_W{1'b0}};
      rem_q       <= {DATA_W{1'b0}};
      rem_sel_q   <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      waddr_q     <= 5'd0;
      result_q    <= {DATA_W{1'b0}};
      ready_q     <= 1'b0;
      waddr_out_q <= 5'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      rem_sel_q   <= rem_sel_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      waddr_q     <= waddr_d;
      result_q    <= result_d;
      ready_q     <= ready_d;
      waddr_out_q <= waddr_out_d;
      busy_q      <= busy_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign reg_we_o    = ready_q;
  assign reg_waddr_o = waddr_out_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_ex_div_2023211063.sv
// Directed testbench for ex_div_2023211063: hand-computed results, latency and handshake checks.
module tb_ex_div_2023211063;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic        busy_o;

  int n_checks;
  int n_pass;

  ex_div_2023211063 dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .reg_waddr_i(reg_waddr_i),
    .flush_i    (flush_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .reg_we_o   (reg_we_o),
    .reg_waddr_o(reg_waddr_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait for ready, check latency/result/handshake.
  // restart=1 re-asserts start with other operands around E5.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa,
                        input logic [31:0] exp_res, input int exp_lat,
                        input bit check_busy, input bit restart);
    int k;
    bit busy_ok;
    @(negedge clk);
    op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = wa; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    k = 0;
    busy_ok = 1'b1;
    while (!ready_o && k < 40) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (restart && k == 4) begin
        op_i = OP_DIVU; dividend_i = 32'd50; divisor_i = 32'd5; reg_waddr_i = 5'd9;
        start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start_i = 1'b0;
    check({tag, " latency"}, 32'(k), 32'(exp_lat));
    if (check_busy) check({tag, " busy held"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " result"}, result_o, exp_res);
    check({tag, " we"}, {31'd0, reg_we_o}, 32'd1);
    check({tag, " waddr"}, {27'd0, reg_waddr_o}, {27'd0, wa});
    check({tag, " busy done"}, {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check({tag, " ready drop"}, {31'd0, ready_o}, 32'd0);
    check({tag, " result hold"}, result_o, exp_res);
  endtask

  initial begin
    int pulses;
    n_checks = 0;
    n_pass = 0;
    rst = 1'b0; start_i = 1'b0; op_i = 3'b000; dividend_i = 32'd0; divisor_i = 32'd0;
    reg_waddr_i = 5'd0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset result", result_o, 32'd0);
    check("reset ready", {31'd0, ready_o}, 32'd0);
    check("reset we", {31'd0, reg_we_o}, 32'd0);
    check("reset waddr", {27'd0, reg_waddr_o}, 32'd0);
    check("reset busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33, 1'b1, 1'b0);
    run_op("remu 100/7", OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2, 33, 1'b1, 1'b0);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 33, 1'b1, 1'b0);
    run_op("rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33, 1'b1, 1'b0);
    run_op("rem 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'd1, 33, 1'b1, 1'b0);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 33, 1'b1, 1'b0);
    run_op("div 1234/0", OP_DIV, 32'd1234, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, 1'b0, 1'b0);
    run_op("remu 1234/0", OP_REMU, 32'd1234, 32'd0, 5'd13, 32'd1234, 1, 1'b0, 1'b0);
    run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 33, 1'b1, 1'b0);
    run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 33, 1'b1, 1'b0);
    run_op("divu x0", OP_DIVU, 32'd81, 32'd9, 5'd0, 32'd9, 33, 1'b1, 1'b0);
    run_op("divu restart", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33, 1'b1, 1'b1);

    // Flush at E10 of a DIVU: no write-back may ever appear.
    @(negedge clk);
    op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush busy", {31'd0, busy_o}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o || reg_we_o) pulses++;
      @(negedge clk);
    end
    check("flush no write", 32'(pulses), 32'd0);
    run_op("divu 9/3", OP_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33, 1'b1, 1'b0);

    // Reset at E20 of a DIVU: everything cleared, no write-back afterwards.
    @(negedge clk);
    op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd5; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst result", result_o, 32'd0);
    check("midrst ready", {31'd0, ready_o}, 32'd0);
    check("midrst we", {31'd0, reg_we_o}, 32'd0);
    check("midrst waddr", {27'd0, reg_waddr_o}, 32'd0);
    check("midrst busy", {31'd0, busy_o}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o || reg_we_o || busy_o) pulses++;
      @(negedge clk);
    end
    check("midrst no write", 32'(pulses), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
